// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the fetch stage, ID stage and CP0.
// Address-error checking on fetch is enabled with the IF_ADEL_CHECK_EN macro.
package if_fetch_stage_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6ffc;
    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc_code;
        logic        bd;
    } if_id_t;

    // Fetch address error: misaligned or outside instruction memory
    function automatic logic adel_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble controls, plus the
// registered reset flag that travels down the pipe alongside it.
module if_id_reg
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] bubble_pc,
    input  if_id_t      fetch,
    output if_id_t      id,
    output logic        reset_out
);

    if_id_t id_reg;
    logic   reset_reg;

    // Bubble beats load; neither means hold (stall)
    always_ff @(posedge clk) begin
        if (reset) begin
            id_reg    <= '{pc: PC_RESET, instr: NOP, exc_code: EXC_NONE, bd: 1'b0};
            reset_reg <= 1'b1;
        end else begin
            reset_reg <= 1'b0;
            if (bubble) begin
                // Bubble keeps the redirect target so EPC stays meaningful
                id_reg <= '{pc: bubble_pc, instr: NOP, exc_code: EXC_NONE, bd: 1'b0};
            end else if (load) begin
                id_reg <= fetch;
            end
        end
    end

    assign id        = id_reg;
    assign reset_out = reset_reg;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage of the P7 MIPS core: PC register, next-PC selection and the
// IF/ID register feeding the decode stage.
// Optional: IF_ADEL_CHECK_EN raises AdEL on misaligned / out-of-range fetch;
// without it the fetch address is simply word-aligned.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [31:0] pcNext_If,
    input  logic        ifBranchOrJump_If,
    input  logic        ifCtrl_Id,
    input  logic        ifEret_If,
    input  logic [31:0] epc,
    input  logic        exc_req,
    output logic        reset_IfId,
    output logic [31:0] pc_IfId,
    output logic [31:0] instr_IfId,
    output logic [4:0]  excCode_IfId,
    output logic        ifBd_IfId
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        load;
    logic        bubble;
    logic [31:0] bubble_pc;
    logic        fetch_fault;
    if_id_t      fetch;
    if_id_t      id;

`ifdef IF_ADEL_CHECK_EN
    assign imem_addr   = pc_reg;
    assign fetch_fault = adel_fault(pc_reg);
`else
    assign imem_addr   = {pc_reg[31:2], 2'b00};
    assign fetch_fault = 1'b0;
`endif

    assign fetch.pc       = pc_reg;
    assign fetch.instr    = fetch_fault ? NOP : imem_rdata;
    assign fetch.exc_code = fetch_fault ? EXC_ADEL : EXC_NONE;
    assign fetch.bd       = ifCtrl_Id;

    // Next-PC selection and IF/ID control; exception outranks stall
    always_comb begin
        pc_next   = pc_reg;
        load      = 1'b0;
        bubble    = 1'b0;
        bubble_pc = EXC_ENTRY;
        if (exc_req) begin
            pc_next   = EXC_ENTRY;
            bubble    = 1'b1;
            bubble_pc = EXC_ENTRY;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (ifEret_If) begin
            pc_next   = epc;
            bubble    = 1'b1;
            bubble_pc = epc;
        end else if (ifBranchOrJump_If) begin
            pc_next = pcNext_If;
            load    = 1'b1;
        end else begin
            pc_next = pc_reg + 32'd4;
            load    = 1'b1;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= PC_RESET;
        end else begin
            pc_reg <= pc_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .bubble    (bubble),
        .bubble_pc (bubble_pc),
        .fetch     (fetch),
        .id        (id),
        .reset_out (reset_IfId)
    );

    assign pc_IfId      = id.pc;
    assign instr_IfId   = id.instr;
    assign excCode_IfId = id.exc_code;
    assign ifBd_IfId    = id.bd;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic [31:0] pcNext_If = 32'h0;
    logic        ifBranchOrJump_If = 1'b0;
    logic        ifCtrl_Id = 1'b0;
    logic        ifEret_If = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        exc_req = 1'b0;
    logic        reset_IfId;
    logic [31:0] pc_IfId;
    logic [31:0] instr_IfId;
    logic [4:0]  excCode_IfId;
    logic        ifBd_IfId;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_id_pc = 32'h0;
    logic [31:0] m_id_instr = 32'h0;
    logic [4:0]  m_id_exc = 5'h0;
    logic        m_id_bd = 1'b0;
    logic        m_rst = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic logic model_fault(input logic [31:0] p);
`ifdef IF_ADEL_CHECK_EN
        return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6ffc);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] p);
`ifdef IF_ADEL_CHECK_EN
        return p;
`else
        return p & ~32'd3;
`endif
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    if_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .stall             (stall),
        .pcNext_If         (pcNext_If),
        .ifBranchOrJump_If (ifBranchOrJump_If),
        .ifCtrl_Id         (ifCtrl_Id),
        .ifEret_If         (ifEret_If),
        .epc               (epc),
        .exc_req           (exc_req),
        .reset_IfId        (reset_IfId),
        .pc_IfId           (pc_IfId),
        .instr_IfId        (instr_IfId),
        .excCode_IfId      (excCode_IfId),
        .ifBd_IfId         (ifBd_IfId)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply the specified priority rules to the model for one clock edge
    task automatic model_edge();
        if (reset) begin
            m_pc = 32'h3000; m_id_pc = 32'h3000; m_id_instr = 0;
            m_id_exc = 0; m_id_bd = 0; m_rst = 1;
        end else begin
            m_rst = 0;
            if (exc_req) begin
                m_pc = 32'h4180; m_id_pc = 32'h4180; m_id_instr = 0; m_id_exc = 0; m_id_bd = 0;
            end else if (stall) begin
                // everything holds
            end else if (ifEret_If) begin
                m_pc = epc; m_id_pc = epc; m_id_instr = 0; m_id_exc = 0; m_id_bd = 0;
            end else begin
                m_id_pc    = m_pc;
                m_id_bd    = ifCtrl_Id;
                m_id_instr = model_fault(m_pc) ? 32'h0 : mem_word(model_addr(m_pc));
                m_id_exc   = model_fault(m_pc) ? 5'd4 : 5'd0;
                m_pc       = ifBranchOrJump_If ? pcNext_If : m_pc + 32'd4;
            end
        end
    endtask

    // One clock: advance model, wait past the edge, compare all outputs
    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check({name, ".imem_addr"}, imem_addr, model_addr(m_pc));
        check({name, ".pc_IfId"}, pc_IfId, m_id_pc);
        check({name, ".instr_IfId"}, instr_IfId, m_id_instr);
        check({name, ".excCode_IfId"}, {27'd0, excCode_IfId}, {27'd0, m_id_exc});
        check({name, ".ifBd_IfId"}, {31'd0, ifBd_IfId}, {31'd0, m_id_bd});
        check({name, ".reset_IfId"}, {31'd0, reset_IfId}, {31'd0, m_rst});
        $display("%-8s addr=%08h id_pc=%08h instr=%08h exc=%0d bd=%0b rst=%0b",
                 name, imem_addr, pc_IfId, instr_IfId, excCode_IfId, ifBd_IfId, reset_IfId);
    endtask

    task automatic idle();
        stall = 0; exc_req = 0; ifEret_If = 0; ifBranchOrJump_If = 0; ifCtrl_Id = 0;
    endtask

    logic [4:0] exp_adel;

    initial begin
`ifdef IF_ADEL_CHECK_EN
        exp_adel = 5'd4;
`else
        exp_adel = 5'd0;
`endif
        // Reset, then free-run
        reset = 1; idle();
        step("reset");
        check("rst.addr", imem_addr, 32'h3000);
        check("rst.flag", {31'd0, reset_IfId}, 32'd1);
        reset = 0;
        step("run1");
        check("run1.addr", imem_addr, 32'h3004);
        check("run1.idpc", pc_IfId, 32'h3000);
        step("run2");
        check("run2.addr", imem_addr, 32'h3008);
        step("run3");
        step("run4");
        check("run4.addr", imem_addr, 32'h3010);

        // Branch with delay slot
        ifBranchOrJump_If = 1; pcNext_If = 32'h3100; ifCtrl_Id = 1;
        step("branch");
        check("br.idpc", pc_IfId, 32'h3010);
        check("br.bd", {31'd0, ifBd_IfId}, 32'd1);
        check("br.target", imem_addr, 32'h3100);
        pcNext_If = 32'h3020;
        step("jmp3020");
        idle();

        // Two-cycle stall at 0x3020
        stall = 1;
        step("stall1");
        step("stall2");
        check("stall.addr", imem_addr, 32'h3020);
        check("stall.idpc", pc_IfId, 32'h3100);
        stall = 0;
        step("release");
        check("release.addr", imem_addr, 32'h3024);

        // Exception during stall
        stall = 1; exc_req = 1;
        step("exc");
        check("exc.addr", imem_addr, 32'h4180);
        check("exc.idpc", pc_IfId, 32'h4180);
        check("exc.instr", instr_IfId, 32'h0);
        idle();
        step("run5");

        // eret, with a simultaneous branch request that must lose
        ifEret_If = 1; epc = 32'h3040; ifBranchOrJump_If = 1; pcNext_If = 32'h3500;
        step("eret");
        check("eret.addr", imem_addr, 32'h3040);
        check("eret.instr", instr_IfId, 32'h0);
        idle();
        step("post_eret");
        check("post_eret.idpc", pc_IfId, 32'h3040);

        // Fetch address errors
        ifBranchOrJump_If = 1; pcNext_If = 32'h3002;
        step("jmp3002");
        idle();
        step("adel1");
        check("adel1.exc", {27'd0, excCode_IfId}, {27'd0, exp_adel});
        ifBranchOrJump_If = 1; pcNext_If = 32'h7000;
        step("jmp7000");
        idle();
        step("adel2");
        check("adel2.exc", {27'd0, excCode_IfId}, {27'd0, exp_adel});

        // Random traffic, including reset mid-stall/mid-redirect
        for (int i = 0; i < 300; i++) begin
            reset             = ($urandom_range(0, 99) < 2);
            stall             = ($urandom_range(0, 99) < 25);
            exc_req           = ($urandom_range(0, 99) < 5);
            ifEret_If         = ($urandom_range(0, 99) < 5);
            ifBranchOrJump_If = ($urandom_range(0, 99) < 20);
            ifCtrl_Id         = ifBranchOrJump_If | ($urandom_range(0, 99) < 10);
            epc               = 32'h3000 + 4 * $urandom_range(0, 4095);
            case ($urandom_range(0, 3))
                0: pcNext_If = 32'h3000 + 4 * $urandom_range(0, 4095);
                1: pcNext_If = $urandom;
                2: pcNext_If = 32'h3000 + $urandom_range(0, 3);
                default: pcNext_If = ($urandom_range(0, 1) != 0) ? 32'h7000 : 32'h2ffc;
            endcase
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
